// File: rtl/instr_mem.sv
// Eight-word instruction store with a registered fetch port and a word-serial reload port.
// Fetches return NOP while a load is in progress so the core never executes a half-written program.
module instr_mem #(
    parameter int                 ADDR_W   = 3,
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instruction,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              loading,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                done_q, done_d;
    logic                wr_en;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        instr_d = NOP_WORD;
        done_d  = 1'b0;
        wr_en   = 1'b0;

        unique case (state_q)
            RUN: begin
                instr_d = mem_q[address];
                if (load_start) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                    count_d = '0;
                end
            end
            LOAD: begin
                // A restart outranks any word offered in the same cycle.
                if (load_start) begin
                    wptr_d  = '0;
                    count_d = '0;
                end else if (load_valid) begin
                    wr_en   = 1'b1;
                    wptr_d  = wptr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W+1)'(1);
                    if (wptr_q == LAST_PTR) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wptr_q  <= '0;
            count_q <= '0;
            instr_q <= NOP_WORD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            instr_q <= instr_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the store is reset to NOP so no stale or partial program survives a reset; this forces flops, not RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (wr_en) begin
            mem_q[wptr_q] <= load_data;
        end
    end

    assign instruction = instr_q;
    assign loading     = (state_q == LOAD);
    assign load_ready  = (state_q == LOAD);
    assign load_done   = done_q;
    assign load_count  = count_q;

endmodule

// File: doc/instr_mem.md
# instr_mem

Eight-word, 32-bit instruction store that answers the processor's instruction fetches. The processor drives a 3-bit `address` and samples `instruction`. This block returns the addressed word one clock later. A word-serial load port with a valid/ready handshake lets the memory be reprogrammed at run time without resynthesis. While a load is in progress, the fetch side is fed a NOP word so the processor never executes a partially written program.

## Interface
- `ADDR_W`, 3: fetch address width; depth = 2^ADDR_W words.
- `DATA_W`, 32: instruction width.
- `NOP_WORD`, 32'h0000_0000: word returned during load and held in every location after reset (opcode 0 is NOP).
- `clk`  in  1  single system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `address`  in  ADDR_W  fetch address from the processor.
- `instruction`  out  DATA_W  registered fetch data.
- `load_start`  in  1  single-cycle request to begin/restart a program load.
- `load_valid`  in  1  `load_data` holds a word to be written.
- `load_data`  in  DATA_W  program word; written in ascending address order from 0.
- `load_ready`  out  1  block accepts a word this cycle.
- `loading`  out  1  high while in LOAD state.
- `load_done`  out  1  one-cycle pulse when the final word is written.
- `load_count`  out  ADDR_W+1  words written in the current/last load (0..8).

## Operation
- States: RUN (serving fetches), LOAD (accepting words).
- RUN behaviour:
  - `instruction` <= mem[`address`] every cycle.
  - `load_ready`=0. `load_valid` and `load_data` are ignored.
  - `load_start`=1 → LOAD; wptr<=0, `load_count`<=0.
- LOAD behaviour:
  - `instruction` <= `NOP_WORD` every cycle. Memory is not read.
  - `load_ready`=1.
  - Transfer occurs when `load_valid`&&`load_ready`: mem[wptr]<=`load_data`, wptr<=wptr+1, `load_count`<=`load_count`+1.
  - Transfer with wptr=2^ADDR_W−1 writes the last word. State → RUN next cycle, and `load_done` pulses with that transition.
- `load_start` during LOAD restarts the load:
  - wptr<=0, `load_count`<=0.
  - A same-cycle `load_valid` word is discarded, not written.
  - Already-written words remain in memory until overwritten.
- `load_start` on the same cycle as the final transfer: restart wins and the word is discarded. State stays LOAD and `load_done` does not pulse.
- wptr is ADDR_W bits and never wraps inside a load, because the state exits at the final word.
- Partial load (source stops sending): the block waits in LOAD indefinitely. Exits are only completion or `rst`.
- `load_count` holds its final value (8) in RUN until the next `load_start`.

## Timing
- Reset (async assert, sync release at next `clk` edge):
  - state=RUN, all memory locations=`NOP_WORD`, `instruction`=`NOP_WORD`.
  - `load_ready`=0, `loading`=0, `load_done`=0, `load_count`=0, wptr=0.
- `rst` during LOAD aborts the load immediately and clears memory; no partial program survives.
- Fetch latency is 1 cycle: `address` sampled at edge N → `instruction` valid after edge N.
- `load_start` at edge N:
  - `loading`=1 and `load_ready`=1 after edge N.
  - The first word is accepted no earlier than edge N+1.
- Maximum load throughput: 1 word/cycle. A full load takes 8 consecutive accepted cycles.
- After the final transfer at edge M:
  - `loading`=0, `load_ready`=0, `load_done`=1 for the cycle after M.
  - `instruction` shows `NOP_WORD` for that cycle.
  - The new mem[`address`] appears after edge M+1.
- No read/write hazard exists, since reads are suppressed in LOAD.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Reset then fetch: assert `rst`, release, sweep `address` 0..7 → `instruction`=32'h0000_0000 each, one cycle after each address change.
- Full back-to-back load:
  - Stimulus: `load_start`, then 8 words 32'h1100_0005, 32'h1200_0003, 32'h2312_0000, 32'hF300_0000, 32'h0, 32'h0, 32'h0, 32'hF100_0000 with `load_valid` high continuously.
  - Required: `load_count` reaches 8 and `load_done` pulses exactly once.
  - Required: `address`=2 returns 32'h2312_0000 and `address`=7 returns 32'hF100_0000.
- Throttled load: toggle `load_valid` 1,0,0,1,… across 8 words → only valid cycles write; final contents match the issued sequence; `instruction`=`NOP_WORD` throughout LOAD.
- Restart mid-load:
  - Stimulus: load 3 words (A,B,C), then `load_start` with `load_valid`=1 and data 32'hDEAD_BEEF.
  - Required: the DEAD_BEEF word is not written and `load_count`=0.
  - Then load 8 words W0..W7 → memory = W0..W7 exactly.
- Reset mid-load:
  - Stimulus: after a complete load, start a second load, write 4 words, then assert `rst` asynchronously between edges.
  - Required: outputs go to reset values immediately.
  - Required: after release, all 8 locations read 32'h0000_0000.
- Collision: `load_start` coincident with the 8th transfer → word discarded, `load_done` stays 0, `loading` stays 1, `load_count`=0.
